rev_cascade_engine: RTL

- Sequential, parametrised successor to the team's single CNOT gate.
- Holds a WIDTH-bit register and a DEPTH-slot program of reversible gates (NOT, CNOT, Toffoli, Fredkin).
- Applies the gates one per clock to an accepted operand.
- Runs forward (compute) or in reverse slot order (uncompute). Every gate is self-inverse, so reverse order exactly inverts forward.
- Sits between the operand source and the reversible ALU datapath, with valid/ready on both sides.

---
 rtl/rev_cascade_engine.sv | 134 +++++++++++++
 1 files changed

// File: rtl/rev_cascade_engine.sv
// Sequential reversible-gate cascade: applies a programmable list of NOT/CNOT/
// Toffoli/Fredkin gates, one per clock, forward or in reverse slot order.
module rev_cascade_engine #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  parameter int ADR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int LEN_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   prog_we,
  input  logic [ADR_W-1:0]       prog_addr,
  input  logic [2+3*IDX_W-1:0]   prog_data,
  input  logic [LEN_W-1:0]       prog_len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_dir,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   err
);

  localparam int PW = 2 + 3 * IDX_W;
  localparam logic [IDX_W:0] WLIM   = (IDX_W + 1)'(WIDTH);
  localparam logic [ADR_W:0] ALIM   = (ADR_W + 1)'(DEPTH);
  localparam logic [LEN_W-1:0] DLEN = LEN_W'(DEPTH);
  localparam logic [LEN_W-1:0] ONE  = LEN_W'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {OP_NOT, OP_CNOT, OP_TOF, OP_FRED} op_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] data;
  logic [LEN_W-1:0] len, step, len_eff, pos;
  logic             dir, err_flag;
  logic [PW-1:0]    mem [DEPTH];

  logic [PW-1:0]    slot;
  op_t              op;
  logic [IDX_W-1:0] t, c1, c2;
  logic             idx_ok, legal, last;
  logic [WIDTH-1:0] gate_out;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = data;
  assign err       = err_flag;

  assign len_eff = (prog_len > DLEN) ? DLEN : prog_len;
  assign last    = (step == len - ONE);
  assign pos     = dir ? (len - ONE - step) : step;
  assign slot    = mem[pos[ADR_W-1:0]];
  assign op      = op_t'(slot[PW-1:PW-2]);
  assign t       = slot[3*IDX_W-1:2*IDX_W];
  assign c1      = slot[2*IDX_W-1:IDX_W];
  assign c2      = slot[IDX_W-1:0];
  assign idx_ok  = ({1'b0, t} < WLIM) && ({1'b0, c1} < WLIM) && ({1'b0, c2} < WLIM);

  // Illegal gates leave the register untouched; legality is judged on the slot
  // fields alone so the err flag does not depend on the data being processed.
  always_comb begin
    gate_out = data;
    legal    = idx_ok;
    case (op)
      OP_NOT:  if (idx_ok) gate_out[t] = ~data[t];
      OP_CNOT: begin
        if (t == c1) legal = 1'b0;
        if (legal) gate_out[t] = data[t] ^ data[c1];
      end
      OP_TOF: begin
        if (t == c1 || t == c2 || c1 == c2) legal = 1'b0;
        if (legal) gate_out[t] = data[t] ^ (data[c1] & data[c2]);
      end
      default: begin
        if (c1 == t || c1 == c2 || t == c2) legal = 1'b0;
        if (legal && data[c1]) begin
          gate_out[t]  = data[c2];
          gate_out[c2] = data[t];
        end
      end
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = (len_eff == '0) ? DONE : RUN;
      RUN:     if (last) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data     <= '0;
      len      <= '0;
      step     <= '0;
      dir      <= 1'b0;
      err_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          data     <= in_data;
          dir      <= in_dir;
          len      <= len_eff;
          step     <= '0;
          err_flag <= 1'b0;
        end
        RUN: begin
          data <= gate_out;
          step <= step + ONE;
          if (!legal) err_flag <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Program memory has no reset so it survives rst; writes only land in IDLE.
  always_ff @(posedge clk) begin
    if (prog_we && state == IDLE && ({1'b0, prog_addr} < ALIM))
      mem[prog_addr] <= prog_data;
  end

endmodule
